fifox_wr_arbiter: RTL and testbench

- Shares the single write port of one FIFOX instance between N requesters.
- Uses round-robin arbitration with a bounded burst lock: a granted requester keeps the port for up to MAX_BURST consecutive items.
- Has a registered output stage and obeys FIFOX FULL/AFULL back-pressure.
- Sits between N producer channels and the FIFOX input side (DI/WR/FULL/AFULL).

---
 rtl/fifox_arb_pkg.sv | 36 +++
 rtl/fifox_rr_pick.sv | 22 ++
 rtl/fifox_wr_arbiter.sv | 120 ++++++++++++
 tb/tb_fifox_wr_arbiter.sv | 278 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/fifox_arb_pkg.sv
// Shared types and helpers for the FIFOX write-port arbiter.
package fifox_arb_pkg;

  localparam int MAX_CH   = 64;  // largest channel count the pick helper handles
  localparam int CH_W_MAX = 6;   // channel index width of the lock record
  localparam int BURST_W  = 16;  // burst counter width of the lock record

  // Width of a channel index; never below one bit.
  function automatic int ch_w(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

  // First set index of vld scanning ptr, ptr+1, ... modulo n; -1 when none set.
  function automatic int rr_pick(input logic [MAX_CH-1:0] vld, input int ptr, input int n);
    int res;
    int idx;
    res = -1;
    idx = 0;
    for (int k = 0; k < MAX_CH; k++) begin
      if (k < n && res < 0) begin
        idx = ptr + k;
        if (idx >= n) idx = idx - n;
        if (vld[idx[CH_W_MAX-1:0]]) res = idx;
      end
    end
    return res;
  endfunction

  // Burst lock state: who holds the port and how many items it has sent.
  typedef struct packed {
    logic                lock_vld;
    logic [CH_W_MAX-1:0] lock_ch;
    logic [BURST_W-1:0]  burst_cnt;
  } lock_state_t;

endpackage

// File: rtl/fifox_rr_pick.sv
// Rotating priority encoder: first valid channel at or after the pointer.
module fifox_rr_pick
  import fifox_arb_pkg::*;
#(
  parameter int CHANNELS = 4,
  parameter int CH_W     = 2
) (
  input  logic [CHANNELS-1:0] vld_i,
  input  logic [CH_W-1:0]     ptr_i,
  output logic                found_o,
  output logic [CH_W-1:0]     idx_o
);

  // Purely combinational scan; returns index 0 when nothing is valid.
  always_comb begin
    int pick;
    pick    = rr_pick(MAX_CH'(vld_i), int'(ptr_i), CHANNELS);
    found_o = (pick >= 0);
    idx_o   = found_o ? CH_W'(pick) : '0;
  end

endmodule

// File: rtl/fifox_wr_arbiter.sv
// Round-robin arbiter with bounded burst lock feeding one FIFOX write port.
module fifox_wr_arbiter
  import fifox_arb_pkg::*;
#(
  parameter int ITEM_WIDTH = 8,
  parameter int CHANNELS   = 4,
  parameter int MAX_BURST  = 4,
  localparam int CH_W      = ch_w(CHANNELS)
) (
  input  logic                           CLK,
  input  logic                           RESET,
  input  logic [CHANNELS*ITEM_WIDTH-1:0] RX_DATA,
  input  logic [CHANNELS-1:0]            RX_VLD,
  output logic [CHANNELS-1:0]            RX_RDY,
  output logic [ITEM_WIDTH-1:0]          DI,
  output logic                           WR,
  input  logic                           FULL,
  input  logic                           AFULL,
  output logic [CH_W-1:0]                GRANT_CH
);

  logic                  out_vld_q, out_vld_d;
  logic [ITEM_WIDTH-1:0] di_q, di_d;
  logic [CH_W-1:0]       grant_q, grant_d;
  logic [CH_W-1:0]       ptr_q, ptr_d;
  lock_state_t           lock_q, lock_d;

  logic                  can_load;
  logic                  pick_found;
  logic [CH_W-1:0]       pick_idx;
  logic [CH_W-1:0]       lock_ch;
  logic [CH_W-1:0]       cand;
  logic                  cand_vld;
  logic                  xfer;
  logic [ITEM_WIDTH-1:0] rx_item [CHANNELS];

  // Next channel after ch, wrapping at CHANNELS (works for non-power-of-2 counts).
  function automatic logic [CH_W-1:0] wrap_inc(input logic [CH_W-1:0] ch);
    return (int'(ch) + 1 >= CHANNELS) ? '0 : CH_W'(int'(ch) + 1);
  endfunction

  fifox_rr_pick #(
    .CHANNELS (CHANNELS),
    .CH_W     (CH_W)
  ) u_pick (
    .vld_i   (RX_VLD),
    .ptr_i   (ptr_q),
    .found_o (pick_found),
    .idx_o   (pick_idx)
  );

  generate
    for (genvar gi = 0; gi < CHANNELS; gi++) begin : g_ch
      assign rx_item[gi] = RX_DATA[gi*ITEM_WIDTH +: ITEM_WIDTH];
      // Gated by RESET so that no handshake is offered while reset is held.
      assign RX_RDY[gi]  = RESET && xfer && (cand == CH_W'(gi));
    end
  endgenerate

  assign lock_ch  = lock_q.lock_ch[CH_W-1:0];
  // A new item may enter only if the output slot frees this cycle and AFULL is low.
  assign can_load = !AFULL && (!out_vld_q || !FULL);
  assign cand     = lock_q.lock_vld ? lock_ch : pick_idx;
  assign cand_vld = lock_q.lock_vld ? RX_VLD[lock_ch] : pick_found;
  assign xfer     = can_load && cand_vld;

  assign WR       = out_vld_q;
  assign DI       = di_q;
  assign GRANT_CH = grant_q;

  // Next-state for the output register, round-robin pointer and burst lock.
  always_comb begin
    out_vld_d = out_vld_q;
    di_d      = di_q;
    grant_d   = grant_q;
    ptr_d     = ptr_q;
    lock_d    = lock_q;
    if (xfer) begin
      out_vld_d = 1'b1;
      di_d      = rx_item[cand];
      grant_d   = cand;
      if (lock_q.burst_cnt + BURST_W'(1) == BURST_W'(MAX_BURST)) begin
        lock_d.lock_vld  = 1'b0;
        lock_d.burst_cnt = '0;
        ptr_d            = wrap_inc(cand);
      end else begin
        lock_d.lock_vld  = 1'b1;
        lock_d.lock_ch   = CH_W_MAX'(cand);
        lock_d.burst_cnt = lock_q.burst_cnt + BURST_W'(1);
      end
    end else begin
      // The held item leaves as soon as FIFOX takes it, even while AFULL blocks loads.
      if (out_vld_q && !FULL) out_vld_d = 1'b0;
      // Locked channel went idle with the port available: give up the lock, one bubble.
      if (can_load && lock_q.lock_vld) begin
        lock_d.lock_vld  = 1'b0;
        lock_d.burst_cnt = '0;
        ptr_d            = wrap_inc(lock_ch);
      end
    end
  end

  // State registers; an asserted reset discards any item held for FIFOX.
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      out_vld_q <= 1'b0;
      di_q      <= '0;
      grant_q   <= '0;
      ptr_q     <= '0;
      lock_q    <= '0;
    end else begin
      out_vld_q <= out_vld_d;
      di_q      <= di_d;
      grant_q   <= grant_d;
      ptr_q     <= ptr_d;
      lock_q    <= lock_d;
    end
  end

endmodule

// File: tb/tb_fifox_wr_arbiter.sv
// Self-checking bench: burst arbiter (MAX_BURST=4) and pure round-robin (MAX_BURST=1).
module tb_fifox_wr_arbiter;

  localparam int IW  = 8;
  localparam int NCH = 4;

  logic                     CLK;
  logic                     RESET;
  logic [1:0][NCH*IW-1:0]   rx_data;
  logic [1:0][NCH-1:0]      rx_vld;
  logic [1:0][NCH-1:0]      rx_rdy;
  logic [1:0][IW-1:0]       di;
  logic [1:0]               wr;
  logic [1:0]               full;
  logic [1:0]               afull;
  logic [1:0][1:0]          grant;

  int checks   = 0;
  int failures = 0;

  typedef struct {
    int         ch;
    logic [7:0] data;
  } exp_t;
  exp_t q0[$];
  exp_t q1[$];

  int seq     [2][NCH];   // producer item index per channel
  int exp_seq [2][NCH];   // expected item index per channel
  logic [NCH-1:0] fire [2];

  typedef struct {
    logic [3:0] vld;
    logic       full;
    logic       afull;
    int         acc;       // channel expected to be accepted this cycle, -1 none
    logic       exp_wr;
    logic [1:0] exp_grant;
    logic [7:0] exp_di;
  } vec_t;
  vec_t tbl [21];

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  fifox_wr_arbiter #(.ITEM_WIDTH(IW), .CHANNELS(NCH), .MAX_BURST(4)) dut (
    .CLK(CLK), .RESET(RESET), .RX_DATA(rx_data[0]), .RX_VLD(rx_vld[0]), .RX_RDY(rx_rdy[0]),
    .DI(di[0]), .WR(wr[0]), .FULL(full[0]), .AFULL(afull[0]), .GRANT_CH(grant[0]));

  fifox_wr_arbiter #(.ITEM_WIDTH(IW), .CHANNELS(NCH), .MAX_BURST(1)) dut1 (
    .CLK(CLK), .RESET(RESET), .RX_DATA(rx_data[1]), .RX_VLD(rx_vld[1]), .RX_RDY(rx_rdy[1]),
    .DI(di[1]), .WR(wr[1]), .FULL(full[1]), .AFULL(afull[1]), .GRANT_CH(grant[1]));

  function automatic logic [7:0] item(input int c, input int s);
    logic [1:0] cc;
    logic [5:0] ss;
    cc = c[1:0];
    ss = s[5:0];
    return {cc, ss} ^ 8'h24;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s act=%0h exp=%0h", name, act, exp);
    end
  endtask

  task automatic build_data();
    for (int d = 0; d < 2; d++)
      for (int c = 0; c < NCH; c++)
        rx_data[d][c*IW +: IW] = item(c, seq[d][c]);
  endtask

  task automatic push(input int d, input int c);
    exp_t e;
    e.ch   = c;
    e.data = item(c, exp_seq[d][c]);
    exp_seq[d][c]++;
    if (d == 0) q0.push_back(e);
    else q1.push_back(e);
  endtask

  task automatic monitor(input int d);
    exp_t e;
    checks++;
    if ((d == 0 && q0.size() == 0) || (d == 1 && q1.size() == 0)) begin
      failures++;
      $display("FAIL sb_unexpected_write_dut%0d act=write exp=none di=%02h", d, di[d]);
    end else begin
      if (d == 0) e = q0.pop_front();
      else e = q1.pop_front();
      $display("WR dut%0d ch=%0d di=%02h (exp ch=%0d di=%02h)", d, grant[d], di[d], e.ch, e.data);
      chk($sformatf("sb_grant_dut%0d", d), 32'(grant[d]), 32'(e.ch));
      chk($sformatf("sb_di_dut%0d", d), 32'(di[d]), 32'(e.data));
    end
  endtask

  // Settle combinational outputs, note handshakes, consume FIFOX writes.
  task automatic settle();
    #1;
    for (int d = 0; d < 2; d++) begin
      fire[d] = rx_vld[d] & rx_rdy[d];
      if (wr[d] && !full[d]) monitor(d);
    end
  endtask

  // Clock edge, then producers advance the channels that handed off an item.
  task automatic advance();
    @(posedge CLK);
    #1;
    for (int d = 0; d < 2; d++)
      for (int c = 0; c < NCH; c++)
        if (fire[d][c]) seq[d][c]++;
    build_data();
  endtask

  task automatic check_reset_outputs(input string tag);
    for (int d = 0; d < 2; d++) begin
      chk($sformatf("%s_wr_dut%0d", tag, d), 32'(wr[d]), 32'd0);
      chk($sformatf("%s_rdy_dut%0d", tag, d), 32'(rx_rdy[d]), 32'd0);
      chk($sformatf("%s_grant_dut%0d", tag, d), 32'(grant[d]), 32'd0);
      chk($sformatf("%s_di_dut%0d", tag, d), 32'(di[d]), 32'd0);
    end
  endtask

  task automatic reset_release();
    @(posedge CLK);
    #1;
    RESET = 1'b1;
    for (int d = 0; d < 2; d++)
      for (int c = 0; c < NCH; c++) begin
        seq[d][c]     = 0;
        exp_seq[d][c] = 0;
        fire[d][c]    = 1'b0;
      end
    q0.delete();
    q1.delete();
    build_data();
  endtask

  task automatic check_sb_empty(input string tag);
    chk($sformatf("%s_sb0_left", tag), 32'(q0.size()), 32'd0);
    chk($sformatf("%s_sb1_left", tag), 32'(q1.size()), 32'd0);
  endtask

  initial begin
    tbl[0]  = '{4'b0100, 1'b0, 1'b0,  2, 1'b0, 2'd0, 8'h00};
    tbl[1]  = '{4'b0001, 1'b0, 1'b0, -1, 1'b1, 2'd2, 8'hA4};
    tbl[2]  = '{4'b0101, 1'b0, 1'b0,  0, 1'b0, 2'd0, 8'h00};
    tbl[3]  = '{4'b0000, 1'b0, 1'b0, -1, 1'b1, 2'd0, 8'h24};
    tbl[4]  = '{4'b0000, 1'b0, 1'b0, -1, 1'b0, 2'd0, 8'h00};
    tbl[5]  = '{4'b0100, 1'b0, 1'b0,  2, 1'b0, 2'd0, 8'h00};
    tbl[6]  = '{4'b0100, 1'b1, 1'b0, -1, 1'b1, 2'd2, 8'hA5};
    tbl[7]  = '{4'b0100, 1'b1, 1'b0, -1, 1'b1, 2'd2, 8'hA5};
    tbl[8]  = '{4'b0100, 1'b1, 1'b0, -1, 1'b1, 2'd2, 8'hA5};
    tbl[9]  = '{4'b0000, 1'b0, 1'b0, -1, 1'b1, 2'd2, 8'hA5};
    tbl[10] = '{4'b0000, 1'b0, 1'b0, -1, 1'b0, 2'd0, 8'h00};
    tbl[11] = '{4'b0010, 1'b0, 1'b0,  1, 1'b0, 2'd0, 8'h00};
    tbl[12] = '{4'b0010, 1'b0, 1'b1, -1, 1'b1, 2'd1, 8'h64};
    tbl[13] = '{4'b0010, 1'b0, 1'b1, -1, 1'b0, 2'd0, 8'h00};
    tbl[14] = '{4'b0010, 1'b0, 1'b1, -1, 1'b0, 2'd0, 8'h00};
    tbl[15] = '{4'b1010, 1'b0, 1'b0,  1, 1'b0, 2'd0, 8'h00};
    tbl[16] = '{4'b1010, 1'b0, 1'b0,  1, 1'b1, 2'd1, 8'h65};
    tbl[17] = '{4'b1010, 1'b0, 1'b0,  1, 1'b1, 2'd1, 8'h66};
    tbl[18] = '{4'b1010, 1'b0, 1'b0,  3, 1'b1, 2'd1, 8'h67};
    tbl[19] = '{4'b0000, 1'b0, 1'b0, -1, 1'b1, 2'd3, 8'hE4};
    tbl[20] = '{4'b0000, 1'b0, 1'b0, -1, 1'b0, 2'd0, 8'h00};

    // Power-up reset with every channel requesting.
    RESET  = 1'b0;
    full   = '0;
    afull  = '0;
    rx_vld = '1;
    build_data();
    #2;
    check_reset_outputs("reset");
    rx_vld[1] = '0;
    reset_release();

    // Continuous traffic on all channels: bursts of 4, rotating 0,1,2,3,0.
    for (int i = 0; i < 20; i++) begin
      rx_vld[0] = '1;
      push(0, (i / 4) % 4);
      settle();
      chk($sformatf("stream_rdy_%0d", i), 32'(rx_rdy[0]), 32'(1) << ((i / 4) % 4));
      chk($sformatf("stream_wr_%0d", i), 32'(wr[0]), (i > 0) ? 32'd1 : 32'd0);
      advance();
    end
    rx_vld[0] = '0;
    settle();
    chk("stream_tail_wr", 32'(wr[0]), 32'd1);
    chk("stream_tail_rdy", 32'(rx_rdy[0]), 32'd0);
    advance();
    settle();
    chk("stream_idle_wr", 32'(wr[0]), 32'd0);
    advance();
    check_sb_empty("stream");

    // Pure round-robin between channels 1 and 3.
    for (int i = 0; i < 8; i++) begin
      rx_vld[1] = 4'b1010;
      push(1, (i % 2 == 1) ? 3 : 1);
      settle();
      chk($sformatf("rr_rdy_%0d", i), 32'(rx_rdy[1]), (i % 2 == 1) ? 32'h8 : 32'h2);
      chk($sformatf("rr_wr_%0d", i), 32'(wr[1]), (i > 0) ? 32'd1 : 32'd0);
      advance();
    end
    rx_vld[1] = '0;
    settle();
    chk("rr_tail_wr", 32'(wr[1]), 32'd1);
    advance();
    settle();
    chk("rr_idle_wr", 32'(wr[1]), 32'd0);
    advance();
    check_sb_empty("rr");

    // Fresh start for the gap / FULL / AFULL sequences.
    RESET = 1'b0;
    #2;
    check_reset_outputs("reset2");
    reset_release();

    for (int i = 0; i < 21; i++) begin
      rx_vld[0] = tbl[i].vld;
      full[0]   = tbl[i].full;
      afull[0]  = tbl[i].afull;
      if (tbl[i].acc >= 0) push(0, tbl[i].acc);
      settle();
      chk($sformatf("row%0d_rdy", i), 32'(rx_rdy[0]),
          (tbl[i].acc >= 0) ? (32'(1) << tbl[i].acc) : 32'd0);
      chk($sformatf("row%0d_wr", i), 32'(wr[0]), 32'(tbl[i].exp_wr));
      if (tbl[i].exp_wr) begin
        chk($sformatf("row%0d_grant", i), 32'(grant[0]), 32'(tbl[i].exp_grant));
        chk($sformatf("row%0d_di", i), 32'(di[0]), 32'(tbl[i].exp_di));
      end
      advance();
    end
    check_sb_empty("table");

    // Asynchronous reset while channel 1 holds the port mid-burst.
    rx_vld[0] = 4'b0010;
    settle();
    chk("mid_rdy", 32'(rx_rdy[0]), 32'h2);
    advance();
    #1;
    chk("mid_wr", 32'(wr[0]), 32'd1);
    chk("mid_grant", 32'(grant[0]), 32'd1);
    chk("mid_di", 32'(di[0]), 32'(item(1, 4)));
    #2;
    RESET = 1'b0;
    #1;
    chk("async_wr", 32'(wr[0]), 32'd0);
    chk("async_grant", 32'(grant[0]), 32'd0);
    chk("async_rdy", 32'(rx_rdy[0]), 32'd0);
    chk("async_di", 32'(di[0]), 32'd0);
    reset_release();
    rx_vld[0] = '1;
    push(0, 0);
    settle();
    chk("restart_rdy", 32'(rx_rdy[0]), 32'h1);
    chk("restart_wr", 32'(wr[0]), 32'd0);
    advance();
    rx_vld[0] = '0;
    settle();
    chk("restart_wr1", 32'(wr[0]), 32'd1);
    advance();
    settle();
    chk("restart_idle_wr", 32'(wr[0]), 32'd0);
    advance();
    check_sb_empty("final");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
